// File: rtl/xalu_ise_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : xalu_ise_issue_if
// Brief    : Request, ISE datapath and response signals between the core and
//            the custom-opcode issue block.
// Revision : 1.0 - initial release
// ============================================================================
interface xalu_ise_issue_if;
    // Pipeline control
    logic        flush;

    // Decoded-stage request channel
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;

    // ISE ALU datapath port
    logic [4:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1;
    logic [31:0] ise_in2;
    logic        ise_val;
    logic        ise_oval;
    logic [31:0] ise_out;

    // Writeback response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    // Issue block side
    modport master (
        input  flush,
        input  req_valid, req_instr, req_rs1, req_rs2,
        output req_ready,
        output ise_fn, ise_imm, ise_in1, ise_in2, ise_val,
        input  ise_oval, ise_out,
        output rsp_valid, rsp_rd, rsp_data, rsp_illegal,
        input  rsp_ready
    );

    // Core / ISE ALU side
    modport slave (
        output flush,
        output req_valid, req_instr, req_rs1, req_rs2,
        input  req_ready,
        input  ise_fn, ise_imm, ise_in1, ise_in2, ise_val,
        output ise_oval, ise_out,
        input  rsp_valid, rsp_rd, rsp_data, rsp_illegal,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/xalu_ise_issue.sv
`default_nettype none
// ============================================================================
// Module   : xalu_ise_issue
// Brief    : Core-side initiator for custom-0..3 ISE ops. Accepts one request,
//            drives the ISE ALU until it claims the op (or a timeout expires)
//            and returns a registered writeback / illegal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
module xalu_ise_issue #(
    parameter int TIMEOUT = 4   // ISSUE cycles without ise_oval before illegal (1..255)
) (
    input  logic              ise_clk,
    input  logic              ise_rst,
    xalu_ise_issue_if.master  bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    // Counter value of the last ISSUE cycle before the op is declared illegal
    localparam logic [7:0] c_last_cnt = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_cnt;
    logic [4:0]  r_fn;
    logic [6:0]  r_imm;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic        r_illegal;

    logic        w_is_custom;
    logic        w_last;
    logic        w_in_issue;
    logic        w_in_resp;
    logic        w_unused;

    // rs1/rs2 register-number fields are not needed; operand values arrive separately
    assign w_unused = ^bus.req_instr[24:15];

    assign w_last = (r_cnt == c_last_cnt);

    // Recognise the four custom major opcodes; the custom index is opcode[6:5]
    always_comb begin
        w_is_custom = 1'b0;
        case (bus.req_instr[6:0])
            7'b0001011, 7'b0101011, 7'b1011011, 7'b1111011: w_is_custom = 1'b1;
            default:                                         w_is_custom = 1'b0;
        endcase
    end

    // State register; reset returns to IDLE
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; flush overrides every transition
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.req_valid) begin
                    w_next_state = w_is_custom ? c_st_issue : c_st_resp;
                end
            end
            c_st_issue: begin
                // oval in the timeout cycle still yields a legal result
                if (bus.ise_oval || w_last) begin
                    w_next_state = c_st_resp;
                end
            end
            c_st_resp: begin
                if (bus.rsp_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
        if (bus.flush) begin
            w_next_state = c_st_idle;
        end
    end

    // Operand latch, timeout counter and response capture
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            r_cnt     <= 8'd0;
            r_fn      <= 5'd0;
            r_imm     <= 7'd0;
            r_in1     <= 32'd0;
            r_in2     <= 32'd0;
            r_rd      <= 5'd0;
            r_data    <= 32'd0;
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_cnt <= 8'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.req_valid) begin
                        r_fn      <= {bus.req_instr[14:12], bus.req_instr[6:5]};
                        r_imm     <= bus.req_instr[31:25];
                        r_in1     <= bus.req_rs1;
                        r_in2     <= bus.req_rs2;
                        r_rd      <= bus.req_instr[11:7];
                        r_cnt     <= 8'd0;
                        r_data    <= 32'd0;
                        r_illegal <= ~w_is_custom;
                    end
                end
                c_st_issue: begin
                    if (bus.ise_oval) begin
                        r_data    <= (r_rd == 5'd0) ? 32'd0 : bus.ise_out;
                        r_illegal <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_last) begin
                            r_data    <= 32'd0;
                            r_illegal <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; everything reads zero while reset is held
    assign w_in_issue = (r_state == c_st_issue) & ~ise_rst;
    assign w_in_resp  = (r_state == c_st_resp)  & ~ise_rst;

    assign bus.req_ready   = (r_state == c_st_idle) & ~ise_rst & ~bus.flush;

    assign bus.ise_val     = w_in_issue;
    assign bus.ise_fn      = w_in_issue ? r_fn  : 5'd0;
    assign bus.ise_imm     = w_in_issue ? r_imm : 7'd0;
    assign bus.ise_in1     = w_in_issue ? r_in1 : 32'd0;
    assign bus.ise_in2     = w_in_issue ? r_in2 : 32'd0;

    assign bus.rsp_valid   = w_in_resp;
    assign bus.rsp_rd      = w_in_resp ? r_rd   : 5'd0;
    assign bus.rsp_data    = w_in_resp ? r_data : 32'd0;
    assign bus.rsp_illegal = w_in_resp & r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_xalu_ise_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_xalu_ise_issue
// Brief    : Self-checking bench for xalu_ise_issue: directed scenarios plus
//            randomized ops compared against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xalu_ise_issue;

    localparam int TIMEOUT = 4;
    localparam logic [6:0] CUSTOM_OPS [4] = '{7'h0B, 7'h2B, 7'h5B, 7'h7B};

    logic ise_clk = 1'b0;
    logic ise_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    xalu_ise_issue_if bus ();

    xalu_ise_issue #(.TIMEOUT(TIMEOUT)) dut (
        .ise_clk (ise_clk),
        .ise_rst (ise_rst),
        .bus     (bus)
    );

    always #5 ise_clk = ~ise_clk;

    // Model: position of the opcode in the custom table, -1 if not custom
    function automatic int custom_index(input logic [31:0] instr);
        int idx = -1;
        for (int k = 0; k < 4; k++) begin
            if (instr[6:0] == CUSTOM_OPS[k]) idx = k;
        end
        return idx;
    endfunction

    task automatic next_cycle();
        @(posedge ise_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_instr = 32'd0;
        bus.req_rs1   = 32'd0;
        bus.req_rs2   = 32'd0;
        bus.ise_oval  = 1'b0;
        bus.ise_out   = 32'd0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.req_valid = 1'b1;
        bus.req_instr = instr;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
    endtask

    task automatic test_reset();
        idle_inputs();
        ise_rst = 1'b1;
        next_cycle();
        next_cycle();
        send_req(32'h0000000B, 32'h1, 32'h2);
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
        end
        n_checks++;
        if ({bus.ise_val, bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd,
             bus.ise_fn, bus.ise_imm, bus.ise_in1, bus.ise_in2} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: ise_val=%b rsp_valid=%b rsp_data=%h not all zero",
                               bus.ise_val, bus.rsp_valid, bus.rsp_data);
        end
        bus.req_valid = 1'b0;
        ise_rst = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_req_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_custom2();
        send_req(32'h0220855B, 32'hF0F01234, 32'h00FF00FF);
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL c2_accept: req_ready=%b want 1", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 1'b0;
        bus.ise_oval  = 1'b1;
        bus.ise_out   = 32'hF0001200;
        #1;
        n_checks++;
        if ({bus.ise_val, bus.ise_fn, bus.ise_imm} !== {1'b1, 5'b00010, 7'h01}) begin
            n_fail++; $display("FAIL c2_issue: val/fn/imm=%h want %h",
                               {bus.ise_val, bus.ise_fn, bus.ise_imm}, {1'b1, 5'b00010, 7'h01});
        end
        n_checks++;
        if ({bus.ise_in1, bus.ise_in2} !== {32'hF0F01234, 32'h00FF00FF}) begin
            n_fail++; $display("FAIL c2_operands: got %h %h want f0f01234 00ff00ff", bus.ise_in1, bus.ise_in2);
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL c2_early_rsp: rsp_valid=%b want 0", bus.rsp_valid);
        end
        next_cycle();
        bus.ise_oval  = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal, bus.ise_val} !==
            {1'b1, 5'd10, 32'hF0001200, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL c2_rsp: valid=%b rd=%0d data=%h illegal=%b ise_val=%b want 1 10 f0001200 0 0",
                               bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal, bus.ise_val);
        end
        next_cycle();
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL c2_back_to_idle: rsp_valid=%b req_ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_non_custom();
        send_req(32'h00000033, $urandom, $urandom);
        next_cycle();
        bus.req_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd, bus.ise_val} !==
            {1'b1, 1'b1, 32'd0, 5'd0, 1'b0}) begin
            n_fail++; $display("FAIL noncustom_rsp: valid=%b illegal=%b data=%h rd=%0d ise_val=%b want 1 1 0 0 0",
                               bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd, bus.ise_val);
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL noncustom_release: rsp_valid=%b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_timeout();
        int val_cycles = 0;
        send_req(32'h000000AB, 32'h11, 32'h22);
        next_cycle();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 20 && bus.ise_val === 1'b1; k++) begin
            val_cycles++;
            next_cycle();
        end
        n_checks++;
        if (val_cycles != TIMEOUT) begin
            n_fail++; $display("FAIL timeout_val_cycles: got %0d want %0d", val_cycles, TIMEOUT);
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd} !== {1'b1, 1'b1, 32'd0, 5'd1}) begin
            n_fail++; $display("FAIL timeout_rsp: valid=%b illegal=%b data=%h rd=%0d want 1 1 0 1",
                               bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd);
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        bus.rsp_ready = 1'b0;
        // Same op, ISE answers in the last permitted cycle
        send_req(32'h000000AB, 32'h33, 32'h44);
        next_cycle();
        bus.req_valid = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            bus.ise_oval = (k == TIMEOUT - 1);
            bus.ise_out  = 32'hCAFE0001;
            next_cycle();
        end
        bus.ise_oval = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_data} !== {1'b1, 1'b0, 32'hCAFE0001}) begin
            n_fail++; $display("FAIL timeout_last_oval: valid=%b illegal=%b data=%h want 1 0 cafe0001",
                               bus.rsp_valid, bus.rsp_illegal, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        send_req(32'h540032FB, 32'h1, 32'h2);
        next_cycle();
        bus.req_valid = 1'b0;
        bus.ise_oval  = 1'b1;
        bus.ise_out   = 32'h12345678;
        next_cycle();
        bus.ise_oval  = 1'b0;
        // A second request waits while the response is stalled
        send_req(32'h0000108B, 32'hA5A5A5A5, 32'h5A5A5A5A);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal, bus.req_ready} !==
                {1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL bp_stall%0d: valid=%b rd=%0d data=%h illegal=%b req_ready=%b want 1 5 12345678 0 0",
                                   k, bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal, bus.req_ready);
            end
            next_cycle();
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_release: rsp_valid=%b req_ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
        end
        next_cycle();
        bus.req_valid = 1'b0;
        bus.ise_oval  = 1'b1;
        bus.ise_out   = 32'h0BADF00D;
        #1;
        n_checks++;
        if ({bus.ise_val, bus.ise_fn, bus.ise_in1} !== {1'b1, 5'b00100, 32'hA5A5A5A5}) begin
            n_fail++; $display("FAIL bp_second_issue: val=%b fn=%b in1=%h want 1 00100 a5a5a5a5",
                               bus.ise_val, bus.ise_fn, bus.ise_in1);
        end
        next_cycle();
        bus.ise_oval  = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data} !== {1'b1, 5'd1, 32'h0BADF00D}) begin
            n_fail++; $display("FAIL bp_second_rsp: valid=%b rd=%0d data=%h want 1 1 0badf00d",
                               bus.rsp_valid, bus.rsp_rd, bus.rsp_data);
        end
        next_cycle();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_rd_zero();
        send_req(32'h0000000B, $urandom, $urandom);
        next_cycle();
        bus.req_valid = 1'b0;
        bus.ise_oval  = 1'b1;
        bus.ise_out   = 32'hDEADBEEF;
        next_cycle();
        bus.ise_oval  = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_illegal, bus.rsp_rd} !== {1'b1, 32'd0, 1'b0, 5'd0}) begin
            n_fail++; $display("FAIL rd_zero: valid=%b data=%h illegal=%b rd=%0d want 1 0 0 0",
                               bus.rsp_valid, bus.rsp_data, bus.rsp_illegal, bus.rsp_rd);
        end
        bus.rsp_ready = 1'b1;
        next_cycle();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_flush();
        int seen_rsp = 0;
        send_req(32'h0000012B, 32'h7, 32'h8);
        next_cycle();
        bus.req_valid = 1'b0;
        next_cycle();
        bus.flush = 1'b1;
        #1;
        n_checks++;
        if ({bus.ise_val, bus.req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL flush_cycle: ise_val=%b req_ready=%b want 1 0", bus.ise_val, bus.req_ready);
        end
        next_cycle();
        bus.flush = 1'b0;
        #1;
        n_checks++;
        if ({bus.ise_val, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL flush_after: ise_val=%b rsp_valid=%b req_ready=%b want 0 0 1",
                               bus.ise_val, bus.rsp_valid, bus.req_ready);
        end
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            if (bus.rsp_valid === 1'b1) seen_rsp++;
        end
        n_checks++;
        if (seen_rsp != 0) begin
            n_fail++; $display("FAIL flush_no_rsp: rsp_valid seen %0d cycles want 0", seen_rsp);
        end
        // Flush in RESP with rsp_ready high and a new request pending
        send_req(32'h00000033, 32'h0, 32'h0);
        next_cycle();
        bus.flush     = 1'b1;
        bus.rsp_ready = 1'b1;
        send_req(32'h0000000B, 32'h9, 32'h9);
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b10) begin
            n_fail++; $display("FAIL flush_resp_cycle: rsp_valid=%b req_ready=%b want 1 0", bus.rsp_valid, bus.req_ready);
        end
        next_cycle();
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.ise_val, bus.req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL flush_resp_after: rsp_valid=%b ise_val=%b req_ready=%b want 0 0 1",
                               bus.rsp_valid, bus.ise_val, bus.req_ready);
        end
    endtask

    task automatic test_reset_in_resp();
        send_req(32'h540032FB, 32'h1, 32'h2);
        next_cycle();
        bus.req_valid = 1'b0;
        bus.ise_oval  = 1'b1;
        bus.ise_out   = 32'hFFFFFFFF;
        next_cycle();
        bus.ise_oval  = 1'b0;
        ise_rst = 1'b1;
        next_cycle();
        n_checks++;
        if ({bus.req_ready, bus.ise_val, bus.rsp_valid, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd,
             bus.ise_fn, bus.ise_imm, bus.ise_in1, bus.ise_in2} !== '0) begin
            n_fail++; $display("FAIL rst_in_resp: req_ready=%b rsp_valid=%b rsp_data=%h not all zero",
                               bus.req_ready, bus.rsp_valid, bus.rsp_data);
        end
        ise_rst = 1'b0;
        next_cycle();
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rst_release: rsp_valid=%b req_ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [31:0] instr = $urandom;
            logic [31:0] rs1   = $urandom;
            logic [31:0] rs2   = $urandom;
            logic [31:0] out   = $urandom;
            int          delay = $urandom_range(0, TIMEOUT + 1);
            int          stall = $urandom_range(0, 2);
            int          idx;
            int          exp_issue;
            int          issue_cycles = 0;
            int          field_err = 0;
            logic        exp_illegal;
            logic [31:0] exp_data;
            logic [4:0]  exp_fn;
            if ($urandom_range(0, 2) != 0) instr[6:0] = CUSTOM_OPS[$urandom_range(0, 3)];
            idx         = custom_index(instr);
            exp_fn      = {instr[14:12], 2'(idx)};
            exp_issue   = (idx < 0) ? 0 : ((delay < TIMEOUT) ? delay + 1 : TIMEOUT);
            exp_illegal = (idx < 0) || (delay >= TIMEOUT);
            exp_data    = (exp_illegal || instr[11:7] == 5'd0) ? 32'd0 : out;

            send_req(instr, rs1, rs2);
            #1;
            n_checks++;
            if (bus.req_ready !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_accept: req_ready=%b want 1", t, bus.req_ready);
            end
            next_cycle();
            bus.req_valid = 1'b0;
            for (int k = 0; k < TIMEOUT + 2 && bus.rsp_valid !== 1'b1; k++) begin
                bus.ise_oval = (k == delay);
                bus.ise_out  = (k == delay) ? out : $urandom;
                #1;
                if (bus.ise_val === 1'b1) begin
                    issue_cycles++;
                    if ({bus.ise_fn, bus.ise_imm, bus.ise_in1, bus.ise_in2} !== {exp_fn, instr[31:25], rs1, rs2})
                        field_err++;
                end
                next_cycle();
            end
            bus.ise_oval = 1'b0;
            n_checks++;
            if (field_err != 0 || issue_cycles != exp_issue) begin
                n_fail++; $display("FAIL rand%0d_issue: instr=%h issue_cycles=%0d want %0d field_err=%0d want 0",
                                   t, instr, issue_cycles, exp_issue, field_err);
            end
            for (int s = 0; s <= stall; s++) begin
                bus.rsp_ready = (s == stall);
                #1;
                n_checks++;
                if ({bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal} !==
                    {1'b1, instr[11:7], exp_data, exp_illegal}) begin
                    n_fail++; $display("FAIL rand%0d_rsp: instr=%h valid=%b rd=%0d data=%h illegal=%b want 1 %0d %h %b",
                                       t, instr, bus.rsp_valid, bus.rsp_rd, bus.rsp_data, bus.rsp_illegal,
                                       instr[11:7], exp_data, exp_illegal);
                end
                next_cycle();
            end
            bus.rsp_ready = 1'b0;
            #1;
            n_checks++;
            if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
                n_fail++; $display("FAIL rand%0d_idle: rsp_valid=%b req_ready=%b want 0 1", t, bus.rsp_valid, bus.req_ready);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_custom2();
        test_non_custom();
        test_timeout();
        test_back_pressure();
        test_rd_zero();
        test_flush();
        test_reset_in_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
